// File: rtl/board_io_conditioner.sv
// Board input conditioner: per-channel 2-flop sync, debounce, edge pulses.
// Optional sticky event/IRQ register enabled by defining BOARD_IO_EVT_LATCH_EN.
module board_io_conditioner #(
    parameter int              NumIn          = 8,
    parameter int              DebounceCycles = 1000,
    parameter logic [NumIn-1:0] ResetLevel    = '0,
    parameter int              CntWidth       = $clog2(DebounceCycles + 1)
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_i,
    input  logic [NumIn-1:0] raw_i,
    output logic [NumIn-1:0] level_o,
    output logic [NumIn-1:0] rise_o,
    output logic [NumIn-1:0] fall_o,
    input  logic [NumIn-1:0] rise_en_i,
    input  logic [NumIn-1:0] fall_en_i,
    input  logic [NumIn-1:0] evt_clr_i,
    output logic [NumIn-1:0] evt_pending_o,
    output logic             irq_o
);

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);

    logic [NumIn-1:0]    r_sync1;
    logic [NumIn-1:0]    r_sync2;
    logic [NumIn-1:0]    r_level;
    logic [NumIn-1:0]    r_rise;
    logic [NumIn-1:0]    r_fall;
    logic [CntWidth-1:0] r_cnt [NumIn];
    logic [NumIn-1:0]    w_accept;

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            r_sync1 <= ResetLevel;
            r_sync2 <= ResetLevel;
        end else begin
            r_sync1 <= raw_i;
            r_sync2 <= r_sync1;
        end
    end

    // A channel flips once its synchronised input has disagreed for DebounceCycles edges.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < NumIn; i++) begin
            w_accept[i] = (r_sync2[i] != r_level[i]) && (r_cnt[i] == CntMax);
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            for (int i = 0; i < NumIn; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumIn; i++) begin
                if ((r_sync2[i] == r_level[i]) || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            r_level <= ResetLevel;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            r_level <= r_level ^ w_accept;
            r_rise  <= w_accept & r_sync2;
            r_fall  <= w_accept & ~r_sync2;
        end
    end

    assign level_o = r_level;
    assign rise_o  = r_rise;
    assign fall_o  = r_fall;

`ifdef BOARD_IO_EVT_LATCH_EN
    logic [NumIn-1:0] r_evt_pending;

    // A new latched edge takes priority over a simultaneous write-1-to-clear.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            r_evt_pending <= '0;
        end else begin
            r_evt_pending <= (r_evt_pending & ~evt_clr_i)
                           | (r_rise & rise_en_i)
                           | (r_fall & fall_en_i);
        end
    end

    assign evt_pending_o = r_evt_pending;
    assign irq_o         = |r_evt_pending;
`else
    logic w_unused_evt;

    assign w_unused_evt  = ^{rise_en_i, fall_en_i, evt_clr_i};
    assign evt_pending_o = '0;
    assign irq_o         = 1'b0;
`endif

endmodule

// File: tb/tb_board_io_conditioner.sv
// Bench for board_io_conditioner: directed steps plus random stimulus checked
// against a history-window reference model; honours BOARD_IO_EVT_LATCH_EN.
module tb_board_io_conditioner;

    localparam int         N  = 8;
    localparam int         D  = 4;
    localparam logic [7:0] RL = 8'h00;
`ifdef BOARD_IO_EVT_LATCH_EN
    localparam bit EVT = 1'b1;
`else
    localparam bit EVT = 1'b0;
`endif

    // clock / reset
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] raw = 8'hFF;
    logic [7:0] ren = 8'h00;
    logic [7:0] fen = 8'h00;
    logic [7:0] clr = 8'h00;
    logic [7:0] level, rise, fall, pend;
    logic       irq;

    always #5 clk = ~clk;

    board_io_conditioner #(
        .NumIn         (N),
        .DebounceCycles(D),
        .ResetLevel    (RL)
    ) dut (
        .clk_sys_i    (clk),
        .rst_sys_i    (rst),
        .raw_i        (raw),
        .level_o      (level),
        .rise_o       (rise),
        .fall_o       (fall),
        .rise_en_i    (ren),
        .fall_en_i    (fen),
        .evt_clr_i    (clr),
        .evt_pending_o(pend),
        .irq_o        (irq)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: a channel's level flips when the last D synchronised
    // samples all disagree with it and no flip happened within those D edges
    logic [7:0] m_s1, m_s2, m_level, m_rise, m_fall, m_pend;
    logic [7:0] hist[$];
    int         last_acc[N];
    int         edge_no = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1    = RL;
        m_s2    = RL;
        m_level = RL;
        m_rise  = '0;
        m_fall  = '0;
        m_pend  = '0;
        hist.delete();
        for (int c = 0; c < N; c++) last_acc[c] = -1000;
    endtask

    task automatic model_edge();
        logic [7:0] acc;
        bit         all_diff;
        acc = '0;
        hist.push_back(m_s2);
        if (hist.size() > D) void'(hist.pop_front());
        for (int c = 0; c < N; c++) begin
            if (hist.size() == D && (edge_no - last_acc[c]) >= D) begin
                all_diff = 1'b1;
                foreach (hist[k]) if (hist[k][c] == m_level[c]) all_diff = 1'b0;
                if (all_diff) begin
                    acc[c]      = 1'b1;
                    last_acc[c] = edge_no;
                end
            end
        end
        if (EVT) m_pend = (m_pend & ~clr) | (m_rise & ren) | (m_fall & fen);
        m_rise  = acc & ~m_level;
        m_fall  = acc & m_level;
        m_level = m_level ^ acc;
        m_s2    = m_s1;
        m_s1    = raw;
        edge_no++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_level"}, level, m_level);
        chk({tag, "_rise"},  rise,  m_rise);
        chk({tag, "_fall"},  fall,  m_fall);
        chk({tag, "_pend"},  pend,  m_pend);
        chk({tag, "_irq"},   irq,   |m_pend);
    endtask

    // driver: called at a negedge, returns at the next negedge
    task automatic step(input logic [7:0] r, input logic [7:0] c, input string tag);
        raw = r;
        clr = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic reset_pulse(input int cycles);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_level", level, RL);
        chk("rst_pulse", {rise, fall}, 16'h0);
        chk("rst_pend",  {pend, 7'h0, irq}, 16'h0);
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        bit         seen;
        model_reset();

        // reset held with all inputs high
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("hold_rst_level", level, 8'h00);
            chk("hold_rst_out", {rise, fall, pend, 7'h0, irq}, 32'h0);
            @(negedge clk);
        end
        raw = 8'h00;
        rst = 1'b0;
        repeat (4) step(8'h00, 8'h00, "idle");

        // clean rise on channel 0: accepted on the 6th edge
        for (int k = 1; k <= 7; k++) begin
            step(8'h01, 8'h00, "rise0");
            chk("rise0_lat_level", level[0], (k >= 6) ? 1'b1 : 1'b0);
            chk("rise0_lat_pulse", rise[0],  (k == 6) ? 1'b1 : 1'b0);
            chk("rise0_others",    level[7:1], 7'h0);
        end

        // glitch of D-1 cycles rejected, D cycles accepted
        seen = 1'b0;
        repeat (3) step(8'h03, 8'h00, "glitch3");
        for (int k = 0; k < 10; k++) begin
            step(8'h01, 8'h00, "glitch3");
            if (rise[1] || fall[1] || level[1]) seen = 1'b1;
        end
        chk("glitch3_quiet", seen, 1'b0);
        seen = 1'b0;
        repeat (4) step(8'h03, 8'h00, "glitch4");
        for (int k = 0; k < 3; k++) begin
            step(8'h01, 8'h00, "glitch4");
            if (rise[1]) seen = 1'b1;
        end
        chk("glitch4_rise", seen, 1'b1);
        repeat (8) step(8'h01, 8'h00, "settle");

        // event latch on channel 2
        ren = 8'h04;
        fen = 8'h04;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(8'h05, 8'h00, "evt_rise");
            seen = rise[2];
        end
        chk("evt_rise_seen", seen, 1'b1);
        step(8'h05, 8'h00, "evt_set");
        chk("evt_set_pend", pend, EVT ? 8'h04 : 8'h00);
        chk("evt_set_irq",  irq,  EVT);
        step(8'h05, 8'h04, "evt_clr");
        chk("evt_clr_pend", pend, 8'h00);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(8'h01, 8'h00, "evt_fall");
            seen = fall[2];
        end
        chk("evt_fall_seen", seen, 1'b1);
        step(8'h01, 8'h04, "evt_setclr");
        chk("evt_setclr_pend", pend, EVT ? 8'h04 : 8'h00);
        step(8'h01, 8'h04, "evt_clr2");
        ren = 8'h00;
        fen = 8'h00;
        repeat (8) step(8'h00, 8'h00, "settle");

        // reset in the middle of a debounce on channel 3
        repeat (4) step(8'h08, 8'h00, "mid");
        reset_pulse(2);
        chk("mid_rst_level3", level[3], 1'b0);
        for (int k = 1; k <= 7; k++) begin
            step(8'h08, 8'h00, "mid_post");
            chk("mid_post_level3", level[3], (k >= 6) ? 1'b1 : 1'b0);
            chk("mid_post_rise3",  rise[3],  (k == 6) ? 1'b1 : 1'b0);
        end
        repeat (4) step(8'h00, 8'h00, "settle");
        repeat (8) step(8'h00, 8'h00, "settle");

        // multi-channel simultaneous edges
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(8'hF0, 8'h00, "multi_rise");
            seen = |rise;
        end
        chk("multi_rise_vec", rise, 8'hF0);
        step(8'hF0, 8'h00, "multi_rise_end");
        chk("multi_rise_one", rise, 8'h00);
        repeat (4) step(8'hF0, 8'hFF, "multi_clr");
        fen = 8'h80;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(8'h30, 8'h00, "multi_fall");
            seen = |fall;
        end
        chk("multi_fall_vec", fall, 8'hC0);
        step(8'h30, 8'h00, "multi_pend");
        chk("multi_fall_one", fall, 8'h00);
        chk("multi_pend_vec", pend, EVT ? 8'h80 : 8'h00);

        // random stimulus against the model
        r = 8'h30;
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            ren = 8'($urandom);
            fen = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                reset_pulse($urandom_range(1, 3));
            end else begin
                step(r, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
